// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   state_t      : control FSM states
//   OP_ADD/OP_SUB: {Q0,Q-1} decode values that select add or subtract of M
//   cnt_bits()   : width of the iteration counter for a given iteration count
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  function automatic int unsigned cnt_bits(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/booth_mult_seq_sum_resta_n.sv
// sum_resta_n: W-bit adder/subtractor.
//   A, B   : operands
//   resta  : 0 = S = A + B, 1 = S = A - B
//   S      : W-bit result
//   c_out  : carry out of the top bit
module sum_resta_n #(
  parameter int W = 8
) (
  output logic [W-1:0] S,
  output logic         c_out,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         resta
);

  logic [W-1:0] b_eff;
  logic [W:0]   full;

  // Subtraction as A + ~B + 1
  always_comb begin
    b_eff = B ^ {W{resta}};
    full  = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, resta};
    S     = full[W-1:0];
    c_out = full[W];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, signed or unsigned.
//   clk, reset (sync, active low)
//   start        : request, sampled only in IDLE
//   signed_mode  : 1 = two's complement operands, 0 = unsigned; sampled with start
//   multiplicand : loaded into M on accept
//   multiplier   : loaded into Q on accept
//   busy         : high in CALC and DONE
//   done         : one-cycle pulse when product becomes valid
//   product      : 2*WIDTH result, held until the next accepted start
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // Operands carry one extra bit so unsigned values look positive to Booth;
  // A has one more bit again so that A -/+ M never overflows.
  localparam int N  = WIDTH + 1;
  localparam int CW = int'(cnt_bits(N));

  state_t state, state_nxt;

  logic [N:0]    a_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  m_reg;
  logic          q_m1;
  logic [CW-1:0] cnt;

  logic [N:0]    m_ext;
  logic [N:0]    add_b;
  logic          add_sub;
  logic [N:0]    sum;
  logic          add_carry;
  logic [N:0]    a_nxt;
  logic [N-1:0]  q_nxt;
  logic          last_iter;

  sum_resta_n #(.W(WIDTH + 2)) u_sum_resta (
    .S     (sum),
    .c_out (add_carry),
    .A     (a_reg),
    .B     (add_b),
    .resta (add_sub)
  );

  // Booth decode, then arithmetic shift of {A,Q,Q-1} in the same cycle
  always_comb begin
    m_ext   = {m_reg[N-1], m_reg};
    add_b   = '0;
    add_sub = 1'b0;
    case ({q_reg[0], q_m1})
      OP_ADD: add_b = m_ext;
      OP_SUB: begin
        add_b   = m_ext;
        add_sub = 1'b1;
      end
      default: ;
    endcase
    a_nxt     = {sum[N], sum[N:1]};
    q_nxt     = {sum[0], q_reg[N-1:1]};
    last_iter = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= '0;
            q_reg <= {signed_mode & multiplier[WIDTH-1], multiplier};
            m_reg <= {signed_mode & multiplicand[WIDTH-1], multiplicand};
            q_m1  <= 1'b0;
            cnt   <= CW'(N);
          end
        end
        S_CALC: begin
          a_reg <= a_nxt;
          q_reg <= q_nxt;
          q_m1  <= q_reg[0];
          cnt   <= cnt - CW'(1);
          // Capture the final iteration's result directly so it is valid with done
          if (last_iter) product <= {a_nxt[WIDTH-2:0], q_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        start16;
  logic        signed_mode16;
  logic [15:0] multiplicand16;
  logic [15:0] multiplier16;
  logic        busy16;
  logic        done16;
  logic [31:0] product16;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .start        (start16),
    .signed_mode  (signed_mode16),
    .multiplicand (multiplicand16),
    .multiplier   (multiplier16),
    .busy         (busy16),
    .done         (done16),
    .product      (product16)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_count = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_count <= done_count + 1;

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic sm, input logic [7:0] a, input logic [7:0] b,
                       input logic push, input logic [15:0] exp);
    @(negedge clk);
    start = 1'b1;
    signed_mode = sm;
    multiplicand = a;
    multiplier = b;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    multiplicand = 8'($urandom);
    multiplier = 8'($urandom);
    signed_mode = 1'($urandom);
  endtask

  // Entered one negedge after the accept edge; latency counts negedges from the accept.
  task automatic wait_done(input string nm, input logic chk_lat, output int done_cyc);
    int k;
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    done_cyc = cyc;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done within 40 cycles", nm);
      return;
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_unexpected: got done with product %0h want no done", nm, product);
    end else begin
      check(nm, 64'(product), 64'(exp_q.pop_front()));
    end
    if (chk_lat) check({nm, "_lat"}, 64'(k), 64'd10);
    check({nm, "_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({nm, "_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic run16(input string nm, input logic sm, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    int k;
    @(negedge clk);
    start16 = 1'b1;
    signed_mode16 = sm;
    multiplicand16 = a;
    multiplier16 = b;
    @(negedge clk);
    start16 = 1'b0;
    multiplicand16 = 16'($urandom);
    multiplier16 = 16'($urandom);
    k = 1;
    while (!done16 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done16) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done within 60 cycles", nm);
      return;
    end
    check(nm, 64'(product16), 64'(exp));
    check({nm, "_lat"}, 64'(k), 64'd18);
    @(negedge clk);
  endtask

  initial begin
    int t1, t2, t3, dc0;

    vecs[0]  = '{1'b1, 8'd7,    8'hFD,  16'hFFEB};
    vecs[1]  = '{1'b1, 8'h80,   8'h80,  16'h4000};
    vecs[2]  = '{1'b1, 8'h80,   8'h7F,  16'hC080};
    vecs[3]  = '{1'b0, 8'd255,  8'd255, 16'hFE01};
    vecs[4]  = '{1'b0, 8'd0,    8'd200, 16'h0000};
    vecs[5]  = '{1'b0, 8'd200,  8'd3,   16'h0258};
    vecs[6]  = '{1'b1, 8'hFF,   8'hFF,  16'h0001};
    vecs[7]  = '{1'b1, 8'd127,  8'd127, 16'h3F01};
    vecs[8]  = '{1'b0, 8'd128,  8'd2,   16'h0100};
    vecs[9]  = '{1'b1, 8'hFB,   8'd6,   16'hFFE2};
    vecs[10] = '{1'b0, 8'hFF,   8'd1,   16'h00FF};
    vecs[11] = '{1'b1, 8'hFF,   8'd1,   16'hFFFF};

    reset = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    start16 = 1'b0;
    signed_mode16 = 1'b0;
    multiplicand16 = '0;
    multiplier16 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_product16", 64'(product16), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].sm, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
      wait_done($sformatf("vec%0d", i), 1'b1, t1);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_hold", i), 64'(product), 64'(vecs[i].exp));
    end
    @(negedge clk);
    check("table_done_count", 64'(done_count), 64'd12);

    // start while busy must be ignored
    dc0 = done_count;
    issue(1'b0, 8'd5, 8'd6, 1'b1, 16'd30);
    repeat (2) @(negedge clk);
    start = 1'b1;
    multiplicand = 8'd9;
    multiplier = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ignore", 1'b0, t1);
    repeat (15) @(negedge clk);
    check("busy_ignore_pulses", 64'(done_count - dc0), 64'd1);
    check("busy_ignore_queue", 64'(exp_q.size()), 64'd0);

    // reset in the middle of a calculation
    issue(1'b1, 8'd7, 8'd7, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    reset = 1'b1;
    issue(1'b0, 8'd3, 8'd4, 1'b1, 16'd12);
    wait_done("after_rst", 1'b1, t1);

    // start held high: back-to-back issue every 11 cycles
    dc0 = done_count;
    @(negedge clk);
    start = 1'b1;
    signed_mode = 1'b0;
    multiplicand = 8'd2;
    multiplier = 8'd3;
    repeat (3) exp_q.push_back(16'd6);
    wait_done("held1", 1'b0, t1);
    wait_done("held2", 1'b0, t2);
    wait_done("held3", 1'b0, t3);
    start = 1'b0;
    check("held_period_a", 64'(t2 - t1), 64'd11);
    check("held_period_b", 64'(t3 - t2), 64'd11);
    repeat (15) @(negedge clk);
    check("held_pulses", 64'(done_count - dc0), 64'd3);
    check("held_queue", 64'(exp_q.size()), 64'd0);

    run16("w16_minmin", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    run16("w16_minmax", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
    run16("w16_umax",   1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
